// File: rtl/id_ex_stage_pkg.sv
// Common package: ALU op codes, operand-select enums and the decoded-instruction
// record shared between decode and the ID/EX pipeline register.
package id_ex_stage_pkg;

  typedef logic [5:0] Vec6;

  localparam Vec6 ALU_SLL = 6'h00;
  localparam Vec6 ALU_SRL = 6'h02;
  localparam Vec6 ALU_ADD = 6'h20;
  localparam Vec6 ALU_SUB = 6'h22;
  localparam Vec6 ALU_AND = 6'h24;
  localparam Vec6 ALU_OR  = 6'h25;

  // Encoding 3 is not named; it selects zero like SRC1_ZERO.
  typedef enum logic [1:0] {
    SRC1_RS    = 2'd0,
    SRC1_SHAMT = 2'd1,
    SRC1_ZERO  = 2'd2
  } Src1Sel;

  typedef enum logic [1:0] {
    SRC2_RT   = 2'd0,
    SRC2_SEXT = 2'd1,
    SRC2_ZEXT = 2'd2,
    SRC2_LUI  = 2'd3
  } Src2Sel;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [4:0]  dest;
    logic        regWrite;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    Vec6         aluOp;
    Src1Sel      src1Sel;
    Src2Sel      src2Sel;
  } DecodedInstr;

  // Empty-stage contents: everything zero except a harmless ADD opcode.
  localparam DecodedInstr INSTR_RESET = '{
    pc: 32'd0, rs: 5'd0, rt: 5'd0, rsData: 32'd0, rtData: 32'd0,
    dest: 5'd0, regWrite: 1'b0, shamt: 5'd0, imm16: 16'd0,
    aluOp: ALU_ADD, src1Sel: SRC1_RS, src2Sel: SRC2_RT
  };

  function automatic logic [31:0] signExt16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Register-operand bypass: picks the youngest in-flight result for a source
// index, falling back to the value held in the pipeline register.
module forward_mux #(
  parameter bit EN = 1'b1
) (
  input  logic [4:0]  idx,
  input  logic [31:0] heldData,
  input  logic        exMemWrite,
  input  logic [4:0]  exMemDest,
  input  logic [31:0] exMemData,
  input  logic        memWbWrite,
  input  logic [4:0]  memWbDest,
  input  logic [31:0] memWbData,
  output logic [31:0] value
);

  // EX/MEM beats MEM/WB; r0 is never bypassed.
  always_comb begin
    value = heldData;
    if (EN && idx != 5'd0) begin
      if (exMemWrite && exMemDest == idx)
        value = exMemData;
      else if (memWbWrite && memWbDest == idx)
        value = memWbData;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and valid/ready handshakes.
//
// state | meaning
// EMPTY | outValid=0, no instruction held, ready for decode
// FULL  | outValid=1, instruction held and presented to execute
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] inPc,
  input  logic [4:0]  inRs,
  input  logic [4:0]  inRt,
  input  logic [31:0] inRsData,
  input  logic [31:0] inRtData,
  input  logic [4:0]  inDest,
  input  logic        inRegWrite,
  input  logic [4:0]  inShamt,
  input  logic [15:0] inImm16,
  input  logic [5:0]  inAluOp,
  input  logic [1:0]  inSrc1Sel,
  input  logic [1:0]  inSrc2Sel,
  input  logic        exMemWrite,
  input  logic [4:0]  exMemDest,
  input  logic [31:0] exMemData,
  input  logic        memWbWrite,
  input  logic [4:0]  memWbDest,
  input  logic [31:0] memWbData,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] aluInput1,
  output logic [31:0] aluInput2,
  output logic [5:0]  aluOp,
  output logic [31:0] outPc,
  output logic [4:0]  outDest,
  output logic        outRegWrite,
  output logic [31:0] outStoreData
);

  DecodedInstr held;
  DecodedInstr incoming;
  logic        fullQ;
  logic        transfer;
  logic        stall;
  logic [31:0] fwdRs;
  logic [31:0] fwdRt;

  assign inReady  = !fullQ || outReady;
  assign transfer = inValid && inReady;
  assign stall    = fullQ && !outReady;

  assign incoming = '{
    pc: inPc, rs: inRs, rt: inRt, rsData: inRsData, rtData: inRtData,
    dest: inDest, regWrite: inRegWrite, shamt: inShamt, imm16: inImm16,
    aluOp: inAluOp, src1Sel: Src1Sel'(inSrc1Sel), src2Sel: Src2Sel'(inSrc2Sel)
  };

  forward_mux #(.EN(FWD_EN)) uFwdRs (
    .idx(held.rs), .heldData(held.rsData),
    .exMemWrite(exMemWrite), .exMemDest(exMemDest), .exMemData(exMemData),
    .memWbWrite(memWbWrite), .memWbDest(memWbDest), .memWbData(memWbData),
    .value(fwdRs)
  );

  forward_mux #(.EN(FWD_EN)) uFwdRt (
    .idx(held.rt), .heldData(held.rtData),
    .exMemWrite(exMemWrite), .exMemDest(exMemDest), .exMemData(exMemData),
    .memWbWrite(memWbWrite), .memWbDest(memWbDest), .memWbData(memWbData),
    .value(fwdRt)
  );

  // Occupancy and held instruction; a stall refreshes operands so results
  // retiring past MEM/WB while we wait are captured rather than lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fullQ <= 1'b0;
      held  <= INSTR_RESET;
    end else if (flush) begin
      fullQ <= 1'b0;
    end else if (transfer) begin
      fullQ <= 1'b1;
      held  <= incoming;
    end else if (stall) begin
      held.rsData <= fwdRs;
      held.rtData <= fwdRt;
    end else if (fullQ && outReady) begin
      fullQ <= 1'b0;
    end
  end

  // Operand construction from the held fields and live forwarding.
  always_comb begin
    aluInput1 = 32'd0;
    aluInput2 = fwdRt;
    case (held.src1Sel)
      SRC1_RS:    aluInput1 = fwdRs;
      SRC1_SHAMT: aluInput1 = {27'd0, held.shamt};
      default:    aluInput1 = 32'd0;
    endcase
    case (held.src2Sel)
      SRC2_RT:   aluInput2 = fwdRt;
      SRC2_SEXT: aluInput2 = signExt16(held.imm16);
      SRC2_ZEXT: aluInput2 = {16'd0, held.imm16};
      SRC2_LUI:  aluInput2 = {held.imm16, 16'd0};
      default:   aluInput2 = fwdRt;
    endcase
  end

  assign outValid     = fullQ;
  assign aluOp        = held.aluOp;
  assign outPc        = held.pc;
  assign outDest      = held.dest;
  assign outRegWrite  = held.regWrite;
  assign outStoreData = fwdRt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a scoreboard of expected ALU-side outputs.
module tb_id_ex_stage;

  localparam logic [5:0] OP_SLL = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_OR  = 6'h25;

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [5:0]  op;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        regW;
  } ExpT;

  logic clk = 1'b0;
  logic reset, flush, inValid, inReady;
  logic [31:0] inPc, inRsData, inRtData;
  logic [4:0]  inRs, inRt, inDest, inShamt;
  logic        inRegWrite;
  logic [15:0] inImm16;
  logic [5:0]  inAluOp;
  logic [1:0]  inSrc1Sel, inSrc2Sel;
  logic        exMemWrite, memWbWrite;
  logic [4:0]  exMemDest, memWbDest;
  logic [31:0] exMemData, memWbData;
  logic        outValid, outReady;
  logic [31:0] aluInput1, aluInput2, outPc, outStoreData;
  logic [5:0]  aluOp;
  logic [4:0]  outDest;
  logic        outRegWrite;

  int  nAsserts = 0;
  int  nFail = 0;
  ExpT sb[$];
  ExpT lastExp;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .inPc(inPc), .inRs(inRs), .inRt(inRt),
    .inRsData(inRsData), .inRtData(inRtData),
    .inDest(inDest), .inRegWrite(inRegWrite),
    .inShamt(inShamt), .inImm16(inImm16), .inAluOp(inAluOp),
    .inSrc1Sel(inSrc1Sel), .inSrc2Sel(inSrc2Sel),
    .exMemWrite(exMemWrite), .exMemDest(exMemDest), .exMemData(exMemData),
    .memWbWrite(memWbWrite), .memWbDest(memWbDest), .memWbData(memWbData),
    .outValid(outValid), .outReady(outReady),
    .aluInput1(aluInput1), .aluInput2(aluInput2), .aluOp(aluOp),
    .outPc(outPc), .outDest(outDest), .outRegWrite(outRegWrite),
    .outStoreData(outStoreData)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic doEdge();
    @(posedge clk);
    #1;
  endtask

  // Reference operand builder, written straight from the operand rules.
  function automatic ExpT model(input logic [31:0] pc, input logic [31:0] rsD,
                                input logic [31:0] rtD, input logic [4:0] dest,
                                input logic regW, input logic [4:0] sh,
                                input logic [15:0] imm, input logic [5:0] op,
                                input logic [1:0] s1, input logic [1:0] s2);
    ExpT e;
    e.pc = pc; e.dest = dest; e.regW = regW; e.op = op; e.sd = rtD;
    case (s1)
      2'd0:    e.a1 = rsD;
      2'd1:    e.a1 = {27'd0, sh};
      default: e.a1 = 32'd0;
    endcase
    case (s2)
      2'd0: e.a2 = rtD;
      2'd1: e.a2 = {{16{imm[15]}}, imm};
      2'd2: e.a2 = {16'd0, imm};
      default: e.a2 = {imm, 16'd0};
    endcase
    return e;
  endfunction

  // Presents one instruction for a single edge; leaves lastExp for the caller.
  task automatic accept(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsD, input logic [31:0] rtD, input logic [4:0] dest,
                        input logic regW, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [5:0] op, input logic [1:0] s1, input logic [1:0] s2);
    inPc = pc; inRs = rs; inRt = rt; inRsData = rsD; inRtData = rtD;
    inDest = dest; inRegWrite = regW; inShamt = sh; inImm16 = imm;
    inAluOp = op; inSrc1Sel = s1; inSrc2Sel = s2;
    inValid = 1'b1;
    #1;
    check("inReady_before_accept", {31'd0, inReady}, 32'd1);
    doEdge();
    inValid = 1'b0;
    inPc = 32'hDEAD_BEEF; inRsData = 32'hDEAD_BEEF; inRtData = 32'hDEAD_BEEF;
    inImm16 = 16'h5A5A; inShamt = 5'd9; inAluOp = OP_OR;
    lastExp = model(pc, rsD, rtD, dest, regW, sh, imm, op, s1, s2);
  endtask

  // Waits (bounded) for a presented instruction, compares it against the
  // scoreboard head and retires it.
  task automatic drain(input string tag);
    ExpT e;
    for (int i = 0; i < 10 && !outValid; i++) doEdge();
    check({tag, "_outValid"}, {31'd0, outValid}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_aluInput1"}, aluInput1, e.a1);
      check({tag, "_aluInput2"}, aluInput2, e.a2);
      check({tag, "_aluOp"}, {26'd0, aluOp}, {26'd0, e.op});
      check({tag, "_storeData"}, outStoreData, e.sd);
      check({tag, "_outPc"}, outPc, e.pc);
      check({tag, "_outDest"}, {27'd0, outDest}, {27'd0, e.dest});
      check({tag, "_regWrite"}, {31'd0, outRegWrite}, {31'd0, e.regW});
    end
    outReady = 1'b1;
    doEdge();
    outReady = 1'b0;
    check({tag, "_empty_after"}, {31'd0, outValid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inPc = '0; inRs = '0; inRt = '0; inRsData = '0; inRtData = '0;
    inDest = '0; inRegWrite = 1'b0; inShamt = '0; inImm16 = '0;
    inAluOp = '0; inSrc1Sel = '0; inSrc2Sel = '0;
    exMemWrite = 1'b0; exMemDest = '0; exMemData = '0;
    memWbWrite = 1'b0; memWbDest = '0; memWbData = '0;

    #1;
    check("rst_outValid", {31'd0, outValid}, 32'd0);
    check("rst_aluOp", {26'd0, aluOp}, {26'd0, OP_ADD});
    check("rst_aluInput1", aluInput1, 32'd0);
    check("rst_aluInput2", aluInput2, 32'd0);
    check("rst_storeData", outStoreData, 32'd0);
    check("rst_inReady", {31'd0, inReady}, 32'd1);
    #2 reset = 1'b0;
    doEdge();

    // Accept and pass through with sign-extended immediate.
    accept(32'h0000_1000, 5'd3, 5'd0, 32'h10, 32'd0, 5'd8, 1'b1, 5'd0, 16'hFFFE, OP_ADD, 2'd0, 2'd1);
    sb.push_back(lastExp);
    check("pass_aluInput2_direct", aluInput2, 32'hFFFF_FFFE);
    drain("pass");

    // Forwarding priority on rs.
    accept(32'h0000_1004, 5'd5, 5'd0, 32'h55, 32'd0, 5'd9, 1'b1, 5'd0, 16'd0, OP_SUB, 2'd0, 2'd0);
    exMemWrite = 1'b1; exMemDest = 5'd5; exMemData = 32'hAAAA;
    memWbWrite = 1'b1; memWbDest = 5'd5; memWbData = 32'hBBBB;
    #1 check("fwd_exmem_wins", aluInput1, 32'hAAAA);
    exMemWrite = 1'b0;
    #1 check("fwd_memwb", aluInput1, 32'hBBBB);
    memWbWrite = 1'b0;
    #1 check("fwd_none_held", aluInput1, 32'h55);
    sb.push_back(lastExp);
    drain("fwd");

    // Index 0 is never forwarded.
    accept(32'h0000_1008, 5'd0, 5'd0, 32'd0, 32'd0, 5'd10, 1'b1, 5'd0, 16'd0, OP_ADD, 2'd0, 2'd0);
    exMemWrite = 1'b1; exMemDest = 5'd0; exMemData = 32'hAAAA;
    memWbWrite = 1'b1; memWbDest = 5'd0; memWbData = 32'hBBBB;
    #1 check("fwd_r0_rs", aluInput1, 32'd0);
    check("fwd_r0_rt", outStoreData, 32'd0);
    exMemWrite = 1'b0; memWbWrite = 1'b0;
    sb.push_back(lastExp);
    drain("r0");

    // Stall refresh: MEM/WB result seen once must survive the stall.
    accept(32'h0000_100C, 5'd0, 5'd7, 32'd0, 32'h99, 5'd0, 1'b0, 5'd0, 16'd0, OP_ADD, 2'd2, 2'd0);
    memWbWrite = 1'b1; memWbDest = 5'd7; memWbData = 32'h1234;
    #1 check("stall_fwd_aluInput2", aluInput2, 32'h1234);
    check("stall_inReady0_a", {31'd0, inReady}, 32'd0);
    doEdge();
    memWbWrite = 1'b0; memWbData = 32'h0;
    #1 check("stall_kept_aluInput2", aluInput2, 32'h1234);
    check("stall_kept_storeData", outStoreData, 32'h1234);
    check("stall_inReady0_b", {31'd0, inReady}, 32'd0);
    doEdge();
    check("stall_still_full", {31'd0, outValid}, 32'd1);
    lastExp.a2 = 32'h1234; lastExp.sd = 32'h1234;
    sb.push_back(lastExp);
    drain("stall");

    // Operand selects.
    accept(32'h0000_1010, 5'd1, 5'd2, 32'h77, 32'h66, 5'd4, 1'b1, 5'd31, 16'h8001, OP_SLL, 2'd1, 2'd3);
    sb.push_back(lastExp);
    drain("shamt_lui");
    accept(32'h0000_1014, 5'd1, 5'd2, 32'h77, 32'h66, 5'd4, 1'b1, 5'd0, 16'h8001, OP_OR, 2'd2, 2'd2);
    sb.push_back(lastExp);
    drain("zero_zext");
    accept(32'h0000_1018, 5'd1, 5'd2, 32'h77, 32'h66, 5'd4, 1'b1, 5'd0, 16'h8001, OP_ADD, 2'd3, 2'd1);
    sb.push_back(lastExp);
    drain("sel3_sext");

    // Flush with a simultaneous transfer: both the held and the incoming die.
    accept(32'h0000_2000, 5'd1, 5'd2, 32'h1, 32'h2, 5'd3, 1'b1, 5'd0, 16'd0, OP_ADD, 2'd0, 2'd0);
    outReady = 1'b1; flush = 1'b1;
    accept(32'h0000_2004, 5'd1, 5'd2, 32'h3, 32'h4, 5'd3, 1'b1, 5'd0, 16'd0, OP_SUB, 2'd0, 2'd0);
    flush = 1'b0; outReady = 1'b0;
    check("flush_outValid", {31'd0, outValid}, 32'd0);
    accept(32'h0000_2008, 5'd6, 5'd7, 32'h600, 32'h700, 5'd11, 1'b1, 5'd0, 16'd0, OP_OR, 2'd0, 2'd0);
    sb.push_back(lastExp);
    drain("after_flush");

    // Asynchronous reset in the middle of a stall.
    accept(32'h0000_3000, 5'd6, 5'd7, 32'h600, 32'h700, 5'd11, 1'b1, 5'd0, 16'd0, OP_SUB, 2'd0, 2'd0);
    doEdge();
    #2 reset = 1'b1;
    #1;
    check("arst_outValid", {31'd0, outValid}, 32'd0);
    check("arst_aluOp", {26'd0, aluOp}, {26'd0, OP_ADD});
    check("arst_aluInput1", aluInput1, 32'd0);
    check("arst_outPc", outPc, 32'd0);
    reset = 1'b0;
    doEdge();
    check("sb_empty_at_end", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and the ALU. It holds one decoded instruction and resolves register-operand forwarding from the EX/MEM and MEM/WB stages. It builds the two 32-bit ALU operands (register, shift amount, extended immediate) and passes `aluOp` through. Valid/ready handshakes on both sides let it stall and flush without losing or duplicating an instruction.

## Interface
Parameters:
- `FWD_EN`, default 1: when 0, forwarding is disabled and register data is used as captured.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous kill of the held instruction and of any same-cycle input.
- `inValid` in 1, `inReady` out 1: decode handshake.
- `inPc` in 32: instruction PC, passed through.
- `inRs`, `inRt` in 5: source register indices.
- `inRsData`, `inRtData` in 32: register-file read data.
- `inDest` in 5, `inRegWrite` in 1: destination register and write enable.
- `inShamt` in 5, `inImm16` in 16: instruction fields.
- `inAluOp` in 6: ALU operation code (`Vec6`).
- `inSrc1Sel` in 2: RS=0, SHAMT=1, ZERO=2, 3 treated as ZERO.
- `inSrc2Sel` in 2: RT=0, SEXT=1, ZEXT=2, LUI=3.
- `exMemWrite` in 1, `exMemDest` in 5, `exMemData` in 32: EX/MEM forwarding source.
- `memWbWrite` in 1, `memWbDest` in 5, `memWbData` in 32: MEM/WB forwarding source.
- `outValid` out 1, `outReady` in 1: execute handshake.
- `aluInput1`, `aluInput2` out 32: ALU operands.
- `aluOp` out 6: ALU operation code.
- `outPc` out 32, `outDest` out 5, `outRegWrite` out 1: passed-through fields.
- `outStoreData` out 32: forwarded rt value, for stores.

## Operation
- Single entry; the state is effectively the `outValid` bit: EMPTY (0) or FULL (1).
- `inReady = !outValid || outReady`.
- A transfer occurs when `inValid && inReady`.
- Edge with transfer and no flush: all `in*` fields are captured and `outValid` becomes 1.
- Edge with `outValid && outReady`, no transfer, no flush: `outValid` becomes 0.
- Edge with flush: `outValid` becomes 0 regardless of other inputs. A same-cycle transfer is consumed and discarded; upstream treats it as accepted.
- Forwarding is applied per source (rs, rt), using the held index:
  - Index 0 is never forwarded and always reads the held data, which decode supplies as 0.
  - Otherwise EX/MEM wins when `exMemWrite` is set and `exMemDest` equals the index.
  - Else MEM/WB wins when `memWbWrite` is set and `memWbDest` equals the index.
  - Else the held data is used.
- Operand refresh: on every edge where the entry stays FULL without a new transfer (stall), the forwarded rs/rt values are written back into the held data registers. A result that leaves MEM/WB during a stall is therefore not lost.
- Operand 1: RS gives forwarded rs; SHAMT gives `{27'b0, shamt}`; ZERO gives 0.
- Operand 2:
  - RT gives forwarded rt.
  - SEXT gives `{{16{imm[15]}}, imm}`.
  - ZEXT gives `{16'b0, imm}`.
  - LUI gives `{imm, 16'b0}`.
- Variable shifts use src1=RS; the ALU consumes only `aluInput1[4:0]`, and this block does not mask it.
- `outStoreData` is always the forwarded rt, independent of `inSrc2Sel`.
- Load-use hazards are not detected here. Decode withholds `inValid` until the loaded value is in EX/MEM or later.

## Timing
- Latency: one cycle. An instruction accepted at edge t is presented after edge t.
- Operand outputs are combinational from the held registers plus the live forwarding inputs. There are no other combinational paths from `in*` to outputs.
- `inReady` is combinational from `outValid` and `outReady`.
- Reset (asynchronous, takes effect immediately, including mid-stall):
  - `outValid=0`.
  - All held fields are 0.
  - `aluOp` is `ALU_ADD`.
  - `aluInput1`, `aluInput2`, `outStoreData` are 0, since the held indices are 0.
- `outValid` never drops while `outReady=0` unless `flush` or `reset` is asserted.

## Structure
- The shared common package gains `Src1Sel` and `Src2Sel` enums (`SRC1_RS`, `SRC1_SHAMT`, `SRC1_ZERO`, `SRC2_RT`, `SRC2_SEXT`, `SRC2_ZEXT`, `SRC2_LUI`).
- It also gains a decoded-instruction packed struct shared with decode.
- ALU op codes remain in the common package.
- One sub-module, `forward_mux`: index, held data and both forwarding sources in, selected value out. It is instantiated twice (rs, rt).

## Test plan
- Accept and pass through: accept `inRs=3`, `inRsData=0x10`, `inSrc2Sel=SEXT`, `imm=0xFFFE`, `aluOp=ALU_ADD`, with no forwarding active.
  - Next cycle: `aluInput1=0x10`, `aluInput2=0xFFFFFFFE`, `outValid=1`.
- Forward priority: held `rs=5`; `exMemDest=5`/`0xAAAA` and `memWbDest=5`/`0xBBBB`, both write-enabled.
  - `aluInput1=0xAAAA`.
  - Drop `exMemWrite`: `aluInput1=0xBBBB`.
  - With `rs=0`: `aluInput1` stays at the held 0.
- Stall refresh: hold `outReady=0`; present `memWbDest=rt`/`0x1234` for one cycle, then deassert it.
  - `aluInput2` and `outStoreData` remain `0x1234`.
  - `inReady=0` throughout the stall.
- Operand selects:
  - `shamt=31`, SHAMT gives `aluInput1=0x1F`.
  - LUI with `imm=0x8001` gives `aluInput2=0x80010000`.
  - ZEXT with `imm=0x8001` gives `aluInput2=0x00008001`.
- Flush with a simultaneous transfer: FULL stage, `outReady=1`, `inValid=1`, `flush=1`.
  - Next cycle `outValid=0`.
  - The following instruction is accepted normally.
- Async reset mid-stall: assert `reset` between edges while FULL.
  - `outValid=0` and `aluOp=ALU_ADD` immediately, without waiting for a clock edge.
